// File: rtl/posit_issue_ctrl.sv
// posit_issue_ctrl: single-outstanding issue/response sequencer that sits in
// front of a posit_unit (add/mul/div). It accepts one request, holds the
// posit_unit start/op_sel/in1/in2 lines steady until done, then presents the
// captured result on a valid/ready response channel. Illegal op codes are
// answered locally with NaR and the error flag.
//
// Optional build macro: POSIT_ISSUE_TIMEOUT_EN
//   When defined, an EXEC watchdog aborts after TIMEOUT_CYCLES cycles without
//   done and returns NaR with the error flag. When undefined, EXEC waits for
//   done indefinitely and no watchdog counter exists.
module posit_issue_ctrl #(
  parameter int N              = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,

  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [1:0]   req_op_i,
  input  logic [N-1:0] req_a_i,
  input  logic [N-1:0] req_b_i,

  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [N-1:0] rsp_result_o,
  output logic         rsp_inf_o,
  output logic         rsp_zero_o,
  output logic         rsp_err_o,

  output logic         pu_start_o,
  output logic [1:0]   pu_op_sel_o,
  output logic [N-1:0] pu_in1_o,
  output logic [N-1:0] pu_in2_o,
  input  logic [N-1:0] pu_out_i,
  input  logic         pu_inf_i,
  input  logic         pu_zero_i,
  input  logic         pu_done_i,

  output logic         busy_o,
  output logic [15:0]  op_count_o
);

  localparam logic [1:0]   OpIllegal = 2'b11;
  localparam logic [N-1:0] NaR       = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state_q, state_d;

  // Operands handed to posit_unit; only a legal request overwrites them so the
  // posit_unit inputs keep their last legal values between operations.
  logic [1:0]   op_q;
  logic [N-1:0] a_q, b_q;

  // Response register, held until the next capture.
  logic [N-1:0] result_q;
  logic         inf_q, zero_q, err_q;
  logic [15:0]  op_count_q;

  // Decoded control strobes from the next-state logic.
  logic accept_legal;
  logic capture_pu;
  logic capture_err;
  logic rsp_fire;
  logic timeout_hit;

`ifdef POSIT_ISSUE_TIMEOUT_EN
  localparam int TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TimerW-1:0] exec_cnt_q;

  // Watchdog: counts EXEC cycles and restarts from zero on every EXEC entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exec_cnt_q <= '0;
    end else if (state_q != EXEC) begin
      exec_cnt_q <= '0;
    end else begin
      exec_cnt_q <= exec_cnt_q + TimerW'(1);
    end
  end

  assign timeout_hit = (state_q == EXEC) &&
                       (exec_cnt_q == TimerW'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the timeout length has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and output decode; done is only looked at while in EXEC and
  // done wins over a coincident watchdog expiry.
  always_comb begin
    state_d      = state_q;
    accept_legal = 1'b0;
    capture_pu   = 1'b0;
    capture_err  = 1'b0;
    rsp_fire     = 1'b0;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    pu_start_o   = 1'b0;
    busy_o       = 1'b1;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) begin
          if (req_op_i == OpIllegal) begin
            capture_err = 1'b1;
            state_d     = RESP;
          end else begin
            accept_legal = 1'b1;
            state_d      = EXEC;
          end
        end
      end

      EXEC: begin
        pu_start_o = 1'b1;
        if (pu_done_i) begin
          capture_pu = 1'b1;
          state_d    = RESP;
        end else if (timeout_hit) begin
          capture_err = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, operand latch, response capture and completion counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      inf_q      <= 1'b0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;

      if (accept_legal) begin
        op_q <= req_op_i;
        a_q  <= req_a_i;
        b_q  <= req_b_i;
      end

      if (capture_pu) begin
        result_q <= pu_out_i;
        inf_q    <= pu_inf_i;
        zero_q   <= pu_zero_i;
        err_q    <= 1'b0;
      end else if (capture_err) begin
        result_q <= NaR;
        inf_q    <= 1'b1;
        zero_q   <= 1'b0;
        err_q    <= 1'b1;
      end

      if (rsp_fire && (op_count_q != 16'hFFFF)) begin
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

  assign pu_op_sel_o  = op_q;
  assign pu_in1_o     = a_q;
  assign pu_in2_o     = b_q;
  assign rsp_result_o = result_q;
  assign rsp_inf_o    = inf_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_err_o    = err_q;
  assign op_count_o   = op_count_q;

endmodule

// File: doc/posit_issue_ctrl.md
Name: posit_issue_ctrl

Overview:
- Sequencing front-end that sits directly upstream of posit_unit (add/mul/div, op_sel 00/01/10).
- Accepts one posit operation at a time from the core-side valid/ready request channel.
- Drives and holds posit_unit start/op_sel/in1/in2 stable until done.
- Captures out/inf/zero into a response register and returns it on a valid/ready response channel. Rejects illegal op codes locally.

Parameters:
- N, 16, posit word width; must match the posit_unit instance.
- TIMEOUT_CYCLES, 64, maximum EXEC cycles before the watchdog aborts (used only with POSIT_ISSUE_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  2  00 add, 01 mul, 10 div, 11 illegal.
- req_a_i  in  N  operand A.
- req_b_i  in  N  operand B.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_result_o  out  N  captured result.
- rsp_inf_o  out  1  captured inf flag.
- rsp_zero_o  out  1  captured zero flag.
- rsp_err_o  out  1  illegal op or timeout.
- pu_start_o  out  1  to posit_unit start.
- pu_op_sel_o  out  2  to posit_unit op_sel.
- pu_in1_o  out  N  to posit_unit in1.
- pu_in2_o  out  N  to posit_unit in2.
- pu_out_i  in  N  from posit_unit out.
- pu_inf_i  in  1  from posit_unit inf.
- pu_zero_i  in  1  from posit_unit zero.
- pu_done_i  in  1  from posit_unit done.
- busy_o  out  1  high whenever state is not IDLE.
- op_count_o  out  16  completed-response counter.

Behaviour:
- Reset (rst_ni low at a clock edge): state goes to IDLE. All outputs 0 except req_ready_o=1. Operand/op/result registers cleared; op_count_o=0; watchdog cleared. Reset mid-operation discards the pending operation with no response.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch op/a/b.
  - If op != 11: go to EXEC.
  - If op == 11: go to RESP with rsp_err_o=1, result=16'h8000 (NaR), inf=1, zero=0. posit_unit is never started.
- EXEC:
  - pu_start_o=1; pu_op_sel_o, pu_in1_o and pu_in2_o driven from latched registers, constant for the whole state.
  - pu_done_i is sampled only in EXEC. It is ignored in IDLE and RESP, and on the acceptance cycle.
  - First EXEC cycle with pu_done_i=1: capture pu_out_i, pu_inf_i and pu_zero_i; err=0; go to RESP.
- RESP:
  - pu_start_o=0, which guarantees at least one start-low cycle between operations.
  - rsp_valid_o=1; response fields held stable until rsp_ready_i.
  - On handshake: go to IDLE; op_count_o increments, saturating at 16'hFFFF.
- Outside RESP, rsp_valid_o=0 and the response fields hold their last values.
- Latency: request accepted at edge t. EXEC holds from t+1. If done is already high in the first EXEC cycle, rsp_valid_o rises at t+2. Minimum request-to-request spacing is 3 cycles.
- No request is accepted in EXEC or RESP (req_ready_o=0). Back-pressure on rsp_ready_i stalls indefinitely with no data loss.
- pu_op_sel_o and pu_in*_o keep their last values while not in EXEC.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: POSIT_ISSUE_TIMEOUT_EN.
- When defined: an EXEC cycle counter is cleared on EXEC entry. If TIMEOUT_CYCLES EXEC cycles elapse without pu_done_i, go to RESP with err=1, result=16'h8000, inf=1, zero=0.
- If pu_done_i and expiry coincide on the same cycle, done wins.
- When undefined: no counter is present and EXEC waits indefinitely for done.

Test Plan:
1. Reset, then add a=16'h4000 b=16'h4000 with a real posit_unit -> rsp_valid_o at t+2, rsp_result_o=16'h4800, err=0, op_count_o=1.
2. Mul a=16'h4800 b=16'h4800 with rsp_ready_i held low for 10 cycles -> result 16'h5000 stays stable, req_ready_o=0 throughout, pu_start_o=0 during RESP.
3. req_op_i=2'b11 -> pu_start_o never asserts, rsp_err_o=1, rsp_result_o=16'h8000, rsp_inf_o=1.
4. Stub posit_unit with done delayed 5 cycles (out=16'h1234) -> pu_in1_o/pu_in2_o constant for 5 EXEC cycles, result 16'h1234 at t+6.
5. rst_ni driven low in EXEC for 1 cycle -> next cycle IDLE, busy_o=0, no response, op_count_o=0.
6. With POSIT_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=8 and stub done tied low -> response after 8 EXEC cycles, err=1, result 16'h8000; done rising on cycle 8 instead gives err=0.
